// File: rtl/udt_cfg_ctrl_pkg.sv
// Shared definitions for the UDT configuration/status controller:
// register offsets, connection-state codes, status codes, command and
// response encodings, and the byte-lane merge helper.
package udt_cfg_ctrl_pkg;

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_CFG_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CONN_BASE  = 8'h08;
    localparam logic [7:0] ADDR_IRQ_STAT   = 8'h1C;
    localparam logic [7:0] ADDR_CFG_BASE   = 8'h20;

    typedef enum logic [2:0] {
        CS_UNOPENED   = 3'd0,
        CS_CONNECTING = 3'd1,
        CS_CONNECTED  = 3'd2,
        CS_CONN_FAIL  = 3'd3,
        CS_CLOSING    = 3'd4,
        CS_CLOSED     = 3'd5,
        CS_CLOSE_FAIL = 3'd6,
        CS_INVALID    = 3'd7
    } conn_state_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ERR_CONN  = 2'd1,
        ST_ERR_RANGE = 2'd2,
        ST_ERR_BUSY  = 2'd3
    } cfg_status_e;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_OPEN  = 2'd1;
    localparam logic [1:0] OP_CLOSE = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        CMD_IDLE  = 1'b0,
        CMD_ISSUE = 1'b1
    } cmd_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return m;
    endfunction

endpackage

// File: rtl/udt_cfg_axil_if.sv
// AXI-Lite slave front end: channel handshakes and response registers.
// A write is accepted when address and data are both presented and no
// response is pending; the core sees a single-cycle wr_en and returns the
// response code combinationally, which is registered with bvalid.
module udt_cfg_axil_if
    import udt_cfg_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_strb,
    input  logic [1:0]  i_wr_resp,
    output logic [7:0]  o_rd_addr,
    input  logic [31:0] i_rd_data
);

    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_unused;

    // Readies are held low while reset is asserted.
    assign w_wr_acc  = i_rst_n & i_awvalid & i_wvalid & ~r_bvalid;
    assign w_rd_acc  = i_rst_n & i_arvalid & ~r_rvalid;

    assign o_awready = w_wr_acc;
    assign o_wready  = w_wr_acc;
    assign o_arready = i_rst_n & ~r_rvalid;

    assign o_wr_en   = w_wr_acc;
    assign o_wr_addr = i_awaddr[7:0];
    assign o_wr_data = i_wdata;
    assign o_wr_strb = i_wstrb;
    assign o_rd_addr = i_araddr[7:0];

    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = RESP_OKAY;

    assign w_unused  = ^{i_awaddr[31:8], i_araddr[31:8]};

    // Write response: captured on accept, held until bready.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= i_wr_resp;
        end else if (i_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read data: captured on accept, held until rready.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rdata  <= i_rd_data;
        end else if (i_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/udt_cfg_ctrl.sv
// UDT configuration/status register block for NUM_SOCK sockets.
// Holds range-checked config words, turns CTRL writes into connect/close
// commands for the Socket Manager, and tracks per-socket connection state
// from Socket Manager reports.
// Optional feature macro: UDT_CFG_IRQ_EN (per-socket state-change interrupt).
//
// Command FSM:
//   state     | meaning
//   CMD_IDLE  | no command outstanding
//   CMD_ISSUE | cmd_valid high, op/sock held until cmd_ready
module udt_cfg_ctrl
    import udt_cfg_ctrl_pkg::*;
#(
    parameter int          NUM_SOCK = 2,
    parameter int          NUM_CFG  = 8,
    parameter logic [31:0] CFG_MAX  = 32'h0000FFFF
) (
    input  logic        ctrl_s_axi_aclk,
    input  logic        ctrl_s_axi_aresetn,
    input  logic [31:0] ctrl_s_axi_awaddr,
    input  logic        ctrl_s_axi_awvalid,
    output logic        ctrl_s_axi_awready,
    input  logic [31:0] ctrl_s_axi_wdata,
    input  logic [3:0]  ctrl_s_axi_wstrb,
    input  logic        ctrl_s_axi_wvalid,
    output logic        ctrl_s_axi_wready,
    output logic [1:0]  ctrl_s_axi_bresp,
    output logic        ctrl_s_axi_bvalid,
    input  logic        ctrl_s_axi_bready,
    input  logic [31:0] ctrl_s_axi_araddr,
    input  logic        ctrl_s_axi_arvalid,
    output logic        ctrl_s_axi_arready,
    output logic [31:0] ctrl_s_axi_rdata,
    output logic [1:0]  ctrl_s_axi_rresp,
    output logic        ctrl_s_axi_rvalid,
    input  logic        ctrl_s_axi_rready,
    input  logic [31:0] udt_state,
    input  logic [1:0]  state_sock,
    input  logic        state_valid,
    output logic        state_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [1:0]  cmd_sock
`ifdef UDT_CFG_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        w_wr_en;
    logic [7:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic [1:0]  w_wr_resp;
    logic [7:0]  w_rd_addr;
    logic [31:0] w_rd_data;

    // Arrays sized to the maximum so 2-/3-bit indices always fit; entries
    // beyond NUM_SOCK/NUM_CFG are never written and stay zero.
    logic [2:0]  r_conn [4];
    logic [31:0] r_cfg  [8];
    logic [1:0]  r_status;

    cmd_state_e  r_cmd_state;
    cmd_state_e  w_cmd_state_nxt;
    logic        w_cmd_load;
    logic [1:0]  r_cmd_op;
    logic [1:0]  r_cmd_sock;

    logic [2:0]  w_cfg_idx;
    logic        w_cfg_hit;
    logic [31:0] w_merged;
    logic        w_any_open;

    logic [1:0]  w_ctrl_op;
    logic [1:0]  w_ctrl_sock;
    logic [2:0]  w_ctrl_cur;
    logic [2:0]  w_ctrl_nxt;
    logic        w_ctrl_issue;
    logic [1:0]  w_ctrl_issue_op;
    logic        w_ctrl_commit;

    logic        w_cfg_we;
    logic        w_status_we;
    logic [1:0]  w_status_nxt;
    logic [3:0]  w_irq_clr;

    logic [2:0]  w_rpt_code;
    logic        w_rpt_hit;
    logic [2:0]  w_rd_conn_idx;
    logic        w_unused;

    udt_cfg_axil_if u_axil_if (
        .i_clk     (ctrl_s_axi_aclk),
        .i_rst_n   (ctrl_s_axi_aresetn),
        .i_awaddr  (ctrl_s_axi_awaddr),
        .i_awvalid (ctrl_s_axi_awvalid),
        .o_awready (ctrl_s_axi_awready),
        .i_wdata   (ctrl_s_axi_wdata),
        .i_wstrb   (ctrl_s_axi_wstrb),
        .i_wvalid  (ctrl_s_axi_wvalid),
        .o_wready  (ctrl_s_axi_wready),
        .o_bresp   (ctrl_s_axi_bresp),
        .o_bvalid  (ctrl_s_axi_bvalid),
        .i_bready  (ctrl_s_axi_bready),
        .i_araddr  (ctrl_s_axi_araddr),
        .i_arvalid (ctrl_s_axi_arvalid),
        .o_arready (ctrl_s_axi_arready),
        .o_rdata   (ctrl_s_axi_rdata),
        .o_rresp   (ctrl_s_axi_rresp),
        .o_rvalid  (ctrl_s_axi_rvalid),
        .i_rready  (ctrl_s_axi_rready),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb),
        .i_wr_resp (w_wr_resp),
        .o_rd_addr (w_rd_addr),
        .i_rd_data (w_rd_data)
    );

    assign w_unused    = ^udt_state[31:3];

    assign w_cfg_idx   = w_wr_addr[4:2];
    assign w_cfg_hit   = (w_wr_addr[7:5] == 3'b001) && (w_wr_addr[1:0] == 2'b00) &&
                         ({29'd0, w_cfg_idx} < 32'(NUM_CFG));
    assign w_merged    = byte_merge(r_cfg[w_cfg_idx], w_wr_data, w_wr_strb);

    assign w_ctrl_op   = w_wr_data[1:0];
    assign w_ctrl_sock = w_wr_data[5:4];
    assign w_ctrl_cur  = r_conn[w_ctrl_sock];

    // Config writes are locked while any socket is in an active state.
    always_comb begin
        w_any_open = 1'b0;
        for (int s = 0; s < NUM_SOCK; s++) begin
            if (r_conn[s] == CS_CONNECTING || r_conn[s] == CS_CONNECTED ||
                r_conn[s] == CS_CLOSING)
                w_any_open = 1'b1;
        end
    end

    // Connection-state transition and command chosen by a CTRL write.
    always_comb begin
        w_ctrl_nxt      = w_ctrl_cur;
        w_ctrl_issue    = 1'b0;
        w_ctrl_issue_op = OP_NONE;
        if (w_ctrl_op == OP_OPEN) begin
            w_ctrl_issue = 1'b1;
            if (w_ctrl_cur == CS_CONNECTING || w_ctrl_cur == CS_CONNECTED) begin
                w_ctrl_nxt      = CS_CONN_FAIL;
                w_ctrl_issue_op = OP_CLOSE;
            end else begin
                w_ctrl_nxt      = CS_CONNECTING;
                w_ctrl_issue_op = OP_OPEN;
            end
        end else if (w_ctrl_op == OP_CLOSE) begin
            if (w_ctrl_cur == CS_CONNECTING || w_ctrl_cur == CS_CONNECTED) begin
                w_ctrl_nxt      = CS_CLOSING;
                w_ctrl_issue    = 1'b1;
                w_ctrl_issue_op = OP_CLOSE;
            end else if (w_ctrl_cur != CS_CLOSING) begin
                w_ctrl_nxt      = CS_CLOSE_FAIL;
            end
        end
    end

    // Write decode: response code and which registers the write updates.
    always_comb begin
        w_wr_resp     = RESP_DECERR;
        w_cfg_we      = 1'b0;
        w_status_we   = 1'b0;
        w_status_nxt  = r_status;
        w_ctrl_commit = 1'b0;
        w_irq_clr     = 4'd0;
        if (w_wr_addr == ADDR_CTRL) begin
            if (!w_wr_strb[0]) begin
                w_wr_resp = RESP_OKAY;
            end else if ({30'd0, w_ctrl_sock} >= 32'(NUM_SOCK)) begin
                w_wr_resp = RESP_DECERR;
            end else if (cmd_valid) begin
                w_wr_resp    = RESP_SLVERR;
                w_status_we  = 1'b1;
                w_status_nxt = ST_ERR_BUSY;
            end else begin
                w_wr_resp     = RESP_OKAY;
                w_ctrl_commit = (w_ctrl_op == OP_OPEN) || (w_ctrl_op == OP_CLOSE);
            end
        end else if (w_wr_addr == ADDR_IRQ_STAT) begin
            w_wr_resp = RESP_OKAY;
`ifdef UDT_CFG_IRQ_EN
            w_irq_clr = w_wr_data[3:0] & {4{w_wr_strb[0]}};
`endif
        end else if (w_cfg_hit) begin
            w_status_we = 1'b1;
            if (w_any_open) begin
                w_wr_resp    = RESP_SLVERR;
                w_status_nxt = ST_ERR_CONN;
            end else if (w_merged == 32'd0 || w_merged > CFG_MAX) begin
                w_wr_resp    = RESP_SLVERR;
                w_status_nxt = ST_ERR_RANGE;
            end else begin
                w_wr_resp    = RESP_OKAY;
                w_status_nxt = ST_OK;
                w_cfg_we     = 1'b1;
            end
        end
    end

    // A committed CTRL write to the reported socket wins over the report.
    assign state_ready = ~(w_wr_en & w_ctrl_commit & (w_ctrl_sock == state_sock));
    assign w_rpt_code  = udt_state[2:0];
    assign w_rpt_hit   = state_valid & state_ready & (w_rpt_code != CS_INVALID) &
                         ({30'd0, state_sock} < 32'(NUM_SOCK));

    // Register file: connection states, config words and status.
    always_ff @(posedge ctrl_s_axi_aclk) begin
        if (!ctrl_s_axi_aresetn) begin
            for (int s = 0; s < 4; s++) r_conn[s] <= CS_UNOPENED;
            for (int i = 0; i < 8; i++) r_cfg[i] <= '0;
            r_status <= ST_OK;
        end else begin
            if (w_rpt_hit)
                r_conn[state_sock] <= w_rpt_code;
            if (w_wr_en && w_ctrl_commit)
                r_conn[w_ctrl_sock] <= w_ctrl_nxt;
            if (w_wr_en && w_cfg_we)
                r_cfg[w_cfg_idx] <= w_merged;
            if (w_wr_en && w_status_we)
                r_status <= w_status_nxt;
        end
    end

    // Command FSM state register.
    always_ff @(posedge ctrl_s_axi_aclk) begin
        if (!ctrl_s_axi_aresetn) r_cmd_state <= CMD_IDLE;
        else                     r_cmd_state <= w_cmd_state_nxt;
    end

    // Command FSM next state.
    always_comb begin
        w_cmd_state_nxt = r_cmd_state;
        w_cmd_load      = 1'b0;
        case (r_cmd_state)
            CMD_IDLE: begin
                if (w_wr_en && w_ctrl_commit && w_ctrl_issue) begin
                    w_cmd_state_nxt = CMD_ISSUE;
                    w_cmd_load      = 1'b1;
                end
            end
            CMD_ISSUE: begin
                if (cmd_ready) w_cmd_state_nxt = CMD_IDLE;
            end
            default: w_cmd_state_nxt = CMD_IDLE;
        endcase
    end

    // Command payload, held stable while cmd_valid is high.
    always_ff @(posedge ctrl_s_axi_aclk) begin
        if (!ctrl_s_axi_aresetn) begin
            r_cmd_op   <= OP_NONE;
            r_cmd_sock <= 2'd0;
        end else if (w_cmd_load) begin
            r_cmd_op   <= w_ctrl_issue_op;
            r_cmd_sock <= w_ctrl_sock;
        end
    end

    assign cmd_valid = (r_cmd_state == CMD_ISSUE);
    assign cmd_op    = r_cmd_op;
    assign cmd_sock  = r_cmd_sock;

`ifdef UDT_CFG_IRQ_EN
    logic [3:0] r_irq_stat;
    logic [3:0] w_irq_set;
    logic [3:0] w_irq_nxt;
    logic       r_irq;

    // Interrupt status: set on a report that changes state; set beats clear.
    always_comb begin
        w_irq_set = 4'd0;
        if (w_rpt_hit && (r_conn[state_sock] != w_rpt_code))
            w_irq_set[state_sock] = 1'b1;
        w_irq_nxt = (r_irq_stat & ~(w_wr_en ? w_irq_clr : 4'd0)) | w_irq_set;
    end

    // Interrupt status and registered interrupt line.
    always_ff @(posedge ctrl_s_axi_aclk) begin
        if (!ctrl_s_axi_aresetn) begin
            r_irq_stat <= 4'd0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_stat <= w_irq_nxt;
            r_irq      <= |w_irq_nxt;
        end
    end

    assign irq = r_irq;
`endif

    assign w_rd_conn_idx = w_rd_addr[4:2] - 3'd2;

    // Read mux; unmapped addresses return zero.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_addr[1:0] == 2'b00) begin
            if (w_rd_addr == ADDR_CFG_STATUS) begin
                w_rd_data = {30'd0, r_status};
            end else if (w_rd_addr[7:5] == 3'b001) begin
                if ({29'd0, w_rd_addr[4:2]} < 32'(NUM_CFG))
                    w_rd_data = r_cfg[w_rd_addr[4:2]];
            end else if (w_rd_addr[7:5] == 3'b000 && w_rd_addr[4:2] >= 3'd2 &&
                         {29'd0, w_rd_conn_idx} < 32'(NUM_SOCK)) begin
                w_rd_data = {29'd0, r_conn[w_rd_conn_idx[1:0]]};
`ifdef UDT_CFG_IRQ_EN
            end else if (w_rd_addr == ADDR_IRQ_STAT) begin
                w_rd_data = {28'd0, r_irq_stat};
`endif
            end
        end
    end

endmodule

// File: tb/tb_udt_cfg_ctrl.sv
// Directed testbench for udt_cfg_ctrl (default parameters).
module tb_udt_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] udt_state;
    logic [1:0]  state_sock;
    logic        state_valid;
    logic        state_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_sock;
`ifdef UDT_CFG_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    udt_cfg_ctrl dut (
        .ctrl_s_axi_aclk    (clk),
        .ctrl_s_axi_aresetn (rst_n),
        .ctrl_s_axi_awaddr  (awaddr),
        .ctrl_s_axi_awvalid (awvalid),
        .ctrl_s_axi_awready (awready),
        .ctrl_s_axi_wdata   (wdata),
        .ctrl_s_axi_wstrb   (wstrb),
        .ctrl_s_axi_wvalid  (wvalid),
        .ctrl_s_axi_wready  (wready),
        .ctrl_s_axi_bresp   (bresp),
        .ctrl_s_axi_bvalid  (bvalid),
        .ctrl_s_axi_bready  (bready),
        .ctrl_s_axi_araddr  (araddr),
        .ctrl_s_axi_arvalid (arvalid),
        .ctrl_s_axi_arready (arready),
        .ctrl_s_axi_rdata   (rdata),
        .ctrl_s_axi_rresp   (rresp),
        .ctrl_s_axi_rvalid  (rvalid),
        .ctrl_s_axi_rready  (rready),
        .udt_state          (udt_state),
        .state_sock         (state_sock),
        .state_valid        (state_valid),
        .state_ready        (state_ready),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_sock           (cmd_sock)
`ifdef UDT_CFG_IRQ_EN
        ,
        .irq                (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        check("wr_accept", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        check("rd_accept", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata; resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check(tag, d, exp);
        check({tag, "_rresp"}, {30'd0, r}, 32'd0);
    endtask

    task automatic wr_expect(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(a, d, s, r);
        check(tag, {30'd0, r}, {30'd0, exp_resp});
    endtask

    task automatic report(input logic [1:0] sock, input logic [31:0] code);
        state_sock = sock; udt_state = code; state_valid = 1'b1;
        #1;
        check("rpt_ready", {31'd0, state_ready}, 32'd1);
        tick();
        state_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; bready = 1'b0;
        araddr = '0; rready = 1'b0;
        udt_state = '0; state_sock = '0; state_valid = 1'b0;
        cmd_ready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick(); tick(); tick();

        // Reset state, with valids asserted to show readies are held low
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_bresp",   {30'd0, bresp}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
`ifdef UDT_CFG_IRQ_EN
        check("rst_irq", {31'd0, irq}, 32'd0);
`endif
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        rd_expect("rst_status", 32'h04, 32'd0);
        rd_expect("rst_conn0",  32'h08, 32'd0);
        rd_expect("rst_cfg0",   32'h20, 32'd0);

        // Test 1: CFG write / read back
        wr_expect("t1_wr_resp", 32'h20, 32'h100, 4'hF, 2'b00);
        rd_expect("t1_cfg0",    32'h20, 32'h100);
        rd_expect("t1_status",  32'h04, 32'd0);

        // Test 2: range checks and byte merge
        wr_expect("t2_over_resp", 32'h20, 32'h0001_0000, 4'hF, 2'b10);
        rd_expect("t2_over_status", 32'h04, 32'd2);
        rd_expect("t2_over_cfg0",   32'h20, 32'h100);
        wr_expect("t2_zero_resp", 32'h20, 32'h0, 4'hF, 2'b10);
        rd_expect("t2_zero_status", 32'h04, 32'd2);
        wr_expect("t2_max_resp",  32'h20, 32'h0000_FFFF, 4'hF, 2'b00);
        rd_expect("t2_max_cfg0",  32'h20, 32'h0000_FFFF);
        wr_expect("t2_merge_resp", 32'h20, 32'hABCD_1234, 4'b0001, 2'b00);
        rd_expect("t2_merge_cfg0", 32'h20, 32'h0000_FF34);
        wr_expect("t2_cfg7_resp", 32'h3C, 32'h5, 4'hF, 2'b00);
        rd_expect("t2_cfg7",      32'h3C, 32'h5);
        rd_expect("t2_ok_status", 32'h04, 32'd0);
        wr_expect("t2_unmapped_wr", 32'h40, 32'h7, 4'hF, 2'b11);
        rd_expect("t2_unmapped_rd", 32'h18, 32'd0);

        // Test 3: connect with stalled Socket Manager
        cmd_ready = 1'b0;
        wr_expect("t3_ctrl_resp", 32'h00, 32'h01, 4'hF, 2'b00);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", {31'd0, cmd_valid}, 32'd1);
            check("t3_hold_op",    {30'd0, cmd_op},    32'd1);
            check("t3_hold_sock",  {30'd0, cmd_sock},  32'd0);
            tick();
        end
        wr_expect("t3_busy_resp", 32'h00, 32'h11, 4'hF, 2'b10);
        rd_expect("t3_busy_status", 32'h04, 32'd3);
        rd_expect("t3_conn0", 32'h08, 32'd1);
        rd_expect("t3_conn1", 32'h0C, 32'd0);
        check("t3_still_valid", {31'd0, cmd_valid}, 32'd1);
        cmd_ready = 1'b1;
        tick();
        check("t3_cleared", {31'd0, cmd_valid}, 32'd0);

        // Test 4: report CONNECTED, then locked CFG and connect-on-connected
        report(2'd0, 32'd2);
        rd_expect("t4_conn0", 32'h08, 32'd2);
`ifdef UDT_CFG_IRQ_EN
        check("t4_irq_set", {31'd0, irq}, 32'd1);
        wr_expect("t4_irq_clr_resp", 32'h1C, 32'h1, 4'hF, 2'b00);
        tick();
        check("t4_irq_clr", {31'd0, irq}, 32'd0);
`endif
        wr_expect("t4_cfg_locked", 32'h20, 32'h200, 4'hF, 2'b10);
        rd_expect("t4_status", 32'h04, 32'd1);
        rd_expect("t4_cfg0_keep", 32'h20, 32'h0000_FF34);
        cmd_ready = 1'b0;
        wr_expect("t4_ctrl_resp", 32'h00, 32'h01, 4'hF, 2'b00);
        check("t4_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        check("t4_cmd_op",    {30'd0, cmd_op},    32'd2);
        check("t4_cmd_sock",  {30'd0, cmd_sock},  32'd0);
        rd_expect("t4_conn0_fail", 32'h08, 32'd3);
        cmd_ready = 1'b1;
        tick();
        check("t4_cleared", {31'd0, cmd_valid}, 32'd0);
        report(2'd0, 32'd7);
        rd_expect("t4_code7_ignored", 32'h08, 32'd3);

        // Test 5: close on UNOPENED, and command-vs-report collision
        wr_expect("t5_close_resp", 32'h00, 32'h12, 4'hF, 2'b00);
        check("t5_no_cmd", {31'd0, cmd_valid}, 32'd0);
        rd_expect("t5_conn1", 32'h0C, 32'd6);

        awaddr = 32'h00; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        state_sock = 2'd1; udt_state = 32'd5; state_valid = 1'b1;
        #1;
        check("t5_collide_aw", {31'd0, awready}, 32'd1);
        check("t5_collide_ready", {31'd0, state_ready}, 32'd0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; state_valid = 1'b0;
        check("t5_collide_bvalid", {31'd0, bvalid}, 32'd1);
        check("t5_collide_bresp",  {30'd0, bresp},  32'd0);
        check("t5_collide_valid",  {31'd0, cmd_valid}, 32'd1);
        check("t5_collide_op",     {30'd0, cmd_op},    32'd1);
        check("t5_collide_sock",   {30'd0, cmd_sock},  32'd1);
        tick();
        bready = 1'b0;
        check("t5_collide_done",   {31'd0, cmd_valid}, 32'd0);
        rd_expect("t5_conn1_cmd_wins", 32'h0C, 32'd1);

        wr_expect("t5_bad_sock", 32'h00, 32'h21, 4'hF, 2'b11);
        wr_expect("t5_strb_off", 32'h00, 32'h12, 4'b1110, 2'b00);
        rd_expect("t5_conn1_keep", 32'h0C, 32'd1);
        check("t5_no_cmd2", {31'd0, cmd_valid}, 32'd0);

        // Test 6: IRQ on state change, then reset during a read
        report(2'd1, 32'd2);
        rd_expect("t6_conn1", 32'h0C, 32'd2);
`ifdef UDT_CFG_IRQ_EN
        check("t6_irq_set", {31'd0, irq}, 32'd1);
        rd_expect("t6_irq_stat", 32'h1C, 32'd2);
        wr_expect("t6_irq_w1c", 32'h1C, 32'h2, 4'hF, 2'b00);
        tick();
        check("t6_irq_clr", {31'd0, irq}, 32'd0);
`else
        rd_expect("t6_irq_stat_off", 32'h1C, 32'd0);
        wr_expect("t6_irq_wr_off", 32'h1C, 32'h2, 4'hF, 2'b00);
`endif
        cmd_ready = 1'b0;
        wr_expect("t6_ctrl_resp", 32'h00, 32'h01, 4'hF, 2'b00);
        check("t6_pending", {31'd0, cmd_valid}, 32'd1);
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        #1;
        tick();
        arvalid = 1'b0;
        check("t6_rvalid_pre", {31'd0, rvalid}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rvalid_rst", {31'd0, rvalid}, 32'd0);
        check("t6_cmd_dropped", {31'd0, cmd_valid}, 32'd0);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick();
        rd_expect("t6_conn0_rst", 32'h08, 32'd0);
        rd_expect("t6_cfg0_rst",  32'h20, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
